timer_counter_ar: RTL

- Parametrised second-generation timer core for the APB timer subsystem. Replaces the fixed 8-bit counter and derived-clock scheme.
- Contains an on-chip prescaler that produces a single-cycle tick enable in the PCLK domain, plus an up/down counter of configurable width.
- Adds auto-reload, compare-match detection and a free-running mode select.
- Sits between control_logic (which drives enable, direction, load, Cks and reload) and Rw_register (which consumes TCNT_Out and the event pulses into TSR).

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_prescaler.sv | 57 +++++
 rtl/timer_counter_ar.sv | 92 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer core: clock-select codes, count
// direction encoding, default widths and the prescale divisor helper.
package timer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CKS_WIDTH  = 2;

    // Clock-select encodings at the default CKS width: divisor = 2^(Cks+1).
    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        logic ovf;
        logic udf;
        logic cmp;
    } timer_evt_t;

    function automatic int unsigned cks_divisor(input int unsigned cks);
        return 32'd1 << (cks + 32'd1);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// PCLK-domain prescaler: emits a registered one-cycle tick every 2^(Cks+1)
// enabled cycles; restarts on clear or whenever Cks changes.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int CKS_WIDTH = DEFAULT_CKS_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CKS_WIDTH-1:0] cks_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    output logic                 tick_o
);

    // Largest divisor is 2^(2^CKS_WIDTH), so its terminal count needs 2^CKS_WIDTH bits.
    localparam int PW = 2 ** CKS_WIDTH;

    logic [PW-1:0]        presc_q;
    logic [PW-1:0]        presc_d;
    logic [PW-1:0]        terminal;
    logic [CKS_WIDTH-1:0] cks_q;
    logic                 cks_change;
    logic                 tick_q;
    logic                 tick_d;

    assign cks_change = (cks_i != cks_q);
    assign terminal   = PW'(cks_divisor(32'(cks_q)) - 32'd1);

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (!enable_i || clear_i || cks_change) begin
            presc_d = '0;
        end else if (presc_q == terminal) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cks_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cks_q   <= cks_i;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/timer_counter_ar.sv
// Up/down timer with auto-reload and compare match. The count register
// advances on the edge after a prescaler tick; event pulses share that edge.
module timer_counter_ar
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CKS_WIDTH  = DEFAULT_CKS_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic [CKS_WIDTH-1:0]  Cks,
    input  logic                  count_enable,
    input  logic                  count_up_down,
    input  logic                  count_load,
    input  logic [DATA_WIDTH-1:0] count_start_value,
    input  logic                  auto_reload,
    input  logic [DATA_WIDTH-1:0] cmp_value,
    output logic [DATA_WIDTH-1:0] TCNT_Out,
    output logic                  Set_OVF_pulse,
    output logic                  Set_UDF_pulse,
    output logic                  Set_CMP_pulse,
    output logic                  tick_out
);

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] cnt_d;
    timer_evt_t            evt_q;
    timer_evt_t            evt_d;
    logic                  tick;
    logic                  wrap;

    timer_prescaler #(
        .CKS_WIDTH (CKS_WIDTH)
    ) u_prescaler (
        .clk_i    (PCLK),
        .rst_ni   (PRESET_n),
        .cks_i    (Cks),
        .enable_i (count_enable),
        .clear_i  (count_load),
        .tick_o   (tick)
    );

    // A load swallows a coincident tick and never raises an event.
    always_comb begin
        cnt_d = cnt_q;
        evt_d = '0;
        wrap  = 1'b0;
        if (count_load) begin
            cnt_d = count_start_value;
        end else if (tick) begin
            if (count_up_down == DIR_UP) begin
                if (cnt_q == CNT_MAX) begin
                    wrap      = 1'b1;
                    evt_d.ovf = 1'b1;
                    cnt_d     = auto_reload ? count_start_value : '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    wrap      = 1'b1;
                    evt_d.udf = 1'b1;
                    cnt_d     = auto_reload ? count_start_value : CNT_MAX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // Reloaded values are not counted values, so they never match.
            evt_d.cmp = (cnt_d == cmp_value) && !(wrap && auto_reload);
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign TCNT_Out      = cnt_q;
    assign Set_OVF_pulse = evt_q.ovf;
    assign Set_UDF_pulse = evt_q.udf;
    assign Set_CMP_pulse = evt_q.cmp;
    assign tick_out      = tick;

endmodule
